// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, fetch FSM encoding and buffer entry type
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        REDIR
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - instruction buffer of {pc,instr}; flush beats push, push+pop allowed when full
module ifetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch stage: owns the PC, reads 1-cycle imem, buffers words for decode
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4,
    input  logic               id_ready
);

    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc;
    logic [ADDR_W-1:0] target;
    logic              inflight;
    logic              active;
    logic              redir_take;
    logic              discard;
    logic              pop;
    logic              push;
    logic              room;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              full;
    logic              empty;
    fetch_entry_t      head;
    fetch_entry_t      push_data;

    assign active     = !reset && (state != BOOT);
    assign redir_take = active && redirect_valid;
    // The word landing this cycle belongs to the old path; the flush drops it as well.
    assign discard    = redir_take;
    assign target     = word_align(redirect_pc);
    assign pop        = if_valid && id_ready;
    assign push       = inflight && !discard;
    assign push_data  = '{pc: inflight_pc, instr: imem_rdata};

    // Words already owned by the buffer once this cycle's pop and landing response settle.
    assign occupancy  = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    assign room       = full ? (pop && !inflight) : (occupancy < DEPTH_C);

    assign imem_req   = redir_take || (active && room);
    assign imem_addr  = redir_take ? target : pc_q;

    assign if_valid    = !reset && !empty;
    assign if_instr    = reset ? NOP : head.instr;
    assign if_pc       = reset ? '0 : head.pc;
    assign if_pc_plus4 = reset ? '0 : head.pc + ADDR_W'(4);

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redir_take),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) inflight_pc <= imem_addr;

            if (redir_take)    pc_q <= target + ADDR_W'(4);
            else if (imem_req) pc_q <= pc_q + ADDR_W'(4);

            case (state)
                BOOT:       state <= RUN;
                RUN, REDIR: state <= redirect_valid ? REDIR : RUN;
                default:    state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - randomized bench for ifetch_unit against a word-stream model
module tb_ifetch_unit;

    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        id_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    ifetch_unit #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C ^ (a >> 2);
    endfunction

    // Synchronous SRAM: data for a request appears the following cycle.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_fn(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model state: words buffered (visible), whether a word lands this cycle,
    // PC of the head word and the next sequential request address.
    logic        m_boot = 1'b1;
    int          m_buf  = 0;
    int          m_pend = 0;
    logic [31:0] m_head = RPC;
    logic [31:0] m_req  = RPC;

    always @(negedge clk) begin
        logic        mv;
        logic        mpop;
        logic        ereq;
        logic [31:0] tgt;
        int          nb;
        if (reset) begin
            chk("rst_req",    {31'b0, imem_req}, 32'd0);
            chk("rst_valid",  {31'b0, if_valid}, 32'd0);
            chk("rst_instr",  if_instr,    32'd0);
            chk("rst_pc",     if_pc,       32'd0);
            chk("rst_pc4",    if_pc_plus4, 32'd0);
            m_boot = 1'b1;
            m_buf  = 0;
            m_pend = 0;
            m_head = RPC;
            m_req  = RPC;
        end else begin
            mv = (m_buf > 0);
            chk("valid", {31'b0, if_valid}, {31'b0, mv});
            if (mv) begin
                chk("head_pc",    if_pc,       m_head);
                chk("head_instr", if_instr,    mem_fn(m_head));
                chk("head_pc4",   if_pc_plus4, m_head + 32'd4);
            end
            mpop = mv && id_ready;
            tgt  = redirect_pc & 32'hFFFF_FFFC;
            if (m_boot) begin
                chk("boot_req", {31'b0, imem_req}, 32'd0);
                m_boot = 1'b0;
                m_pend = 0;
            end else if (redirect_valid) begin
                chk("redir_req",  {31'b0, imem_req}, 32'd1);
                chk("redir_addr", imem_addr, tgt);
                m_buf  = 0;
                m_pend = 1;
                m_head = tgt;
                m_req  = tgt + 32'd4;
            end else begin
                nb   = m_buf + m_pend - int'(mpop);
                ereq = (nb < DEPTH);
                chk("req", {31'b0, imem_req}, {31'b0, ereq});
                if (ereq) begin
                    chk("req_addr", imem_addr, m_req);
                    m_req = m_req + 32'd4;
                end
                if (mpop) m_head = m_head + 32'd4;
                m_buf  = nb;
                m_pend = int'(ereq);
            end
        end
    end

    logic [31:0] held;

    initial begin
        // Reset, BOOT, first request and first delivery
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t1_boot_req", {31'b0, imem_req}, 32'd0);
        tick();
        @(negedge clk);
        chk("t1_first_req",  {31'b0, imem_req}, 32'd1);
        chk("t1_first_addr", imem_addr, 32'h0040_0000);
        tick();
        tick();
        @(negedge clk);
        chk("t1_valid", {31'b0, if_valid}, 32'd1);
        chk("t1_pc",    if_pc,       32'h0040_0000);
        chk("t1_pc4",   if_pc_plus4, 32'h0040_0004);

        // Straight-line: one instruction per cycle
        for (int k = 1; k < 10; k++) begin
            tick();
            @(negedge clk);
            chk("t2_valid", {31'b0, if_valid}, 32'd1);
            chk("t2_pc",    if_pc, 32'h0040_0000 + 32'(4 * k));
            chk("t2_instr", if_instr, mem_fn(32'h0040_0000 + 32'(4 * k)));
        end

        // Stall then resume
        tick();
        id_ready = 1'b0;
        @(negedge clk);
        held = if_pc;
        repeat (3) begin
            tick();
            @(negedge clk);
            chk("t3_hold", if_pc, held);
        end
        tick();
        id_ready = 1'b1;
        @(negedge clk);
        chk("t3_resume0", if_pc, held);
        tick();
        @(negedge clk);
        chk("t3_resume1", if_pc, held + 32'd4);

        // Redirect with a full buffer
        id_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0100;
        @(negedge clk);
        chk("t4_addr", imem_addr, 32'h0040_0100);
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        chk("t4_gap", {31'b0, if_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("t4_pc", if_pc, 32'h0040_0100);

        // Back-to-back redirects and a misaligned target
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0200;
        tick();
        redirect_pc    = 32'h0040_0300;
        tick();
        redirect_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_pc0", if_pc, 32'h0040_0300);
        tick();
        @(negedge clk);
        chk("t5_pc1", if_pc, 32'h0040_0304);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0203;
        @(negedge clk);
        chk("t5_misalign", imem_addr, 32'h0040_0200);
        tick();
        redirect_valid = 1'b0;

        // Reset mid-stream
        id_ready = 1'b0;
        repeat (3) tick();
        id_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_valid", {31'b0, if_valid}, 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("t6_pc", if_pc, 32'h0040_0000);

        // PC wrap
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        tick();
        @(negedge clk);
        chk("wrap_pc",  if_pc,       32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc_plus4, 32'h0000_0000);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            tick();
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom();
            reset          = ($urandom_range(0, 99) == 0);
        end
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        repeat (10) tick();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
